reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with integrated write-pending scoreboard for the pipelined MIPS datapath. It provides two asynchronous read ports, one clocked write port and a write-through bypass. A per-register busy bit is set when an instruction targeting that register issues and cleared on its writeback, so the decode stage can detect RAW/WAW hazards without extra logic. It replaces the fixed 32×32 register bank in the ID/WB stages.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = array value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
- INIT_TEST, 0, 1 = reset loads test values into registers 8..23; 0 = reset clears all to 0

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears or initialises all state
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data (combinational)
- rd_busy1, rd_busy2  out  1  addressed register has a pending write
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back register
- wr_data  in  DATA_W  write-back data
- issue_en  in  1  request to mark issue_addr pending
- issue_addr  in  ADDR_W  destination of issuing instruction
- issue_ok  out  1  issue accepted this cycle (combinational)
- pending_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W × DATA_W array plus 2**ADDR_W busy bits.
- Reset (async, any time, including mid-write or mid-issue): all busy bits 0, pending_cnt 0; registers 0 unless INIT_TEST=1, then regs 8..23 = 10,20,22,40,50,60,70,80,1,2,0,4,5,6,7,8 and the rest 0.
- Write: on rising clk with wr_en=1, array[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writes are edge-triggered only; wr_en level changes never write. With ZERO_REG=1, writes to address 0 are discarded.
- Write to a non-busy register is legal: data written, busy stays 0.
- Read: rd_dataN = array[rd_addrN]. With BYPASS=1 and wr_en=1, wr_addr==rd_addrN (nonzero when ZERO_REG=1): rd_dataN = wr_data and rd_busyN = 0. With ZERO_REG=1, address 0 always reads 0 with busy 0.
- Issue: issue_ok = issue_en & (!busy[issue_addr] | (wr_en & wr_addr==issue_addr)). With ZERO_REG=1 and issue_addr=0: issue_ok = issue_en and no bit is set.
- On rising clk with issue_ok=1: busy[issue_addr] <= 1. If the same register is written back in the same cycle, set wins: busy ends at 1 and the data is written.
- issue_en on a busy register without a matching writeback: issue_ok=0, no state change (WAW stall).
- pending_cnt = population count of busy bits, registered. It updates in the same edge as the bits: +1 for an accepted issue, −1 for a clear of a set bit, net 0 when both target the same register.

## Timing
- Read ports: zero-cycle combinational from address/array/write inputs.
- Write latency: visible from the array 1 cycle after the edge; visible same cycle via bypass when BYPASS=1.
- Busy bit: set visible on rd_busyN the cycle after the issue edge; cleared combinationally during the writeback cycle (BYPASS=1) or after the edge (BYPASS=0).
- issue_ok is combinational; the caller must hold issue_en/issue_addr stable around the edge.
- No internal pipeline; 1 write and 1 issue per cycle maximum.

## Test plan
- Reset with INIT_TEST=1 -> rd_addr1=8 reads 10, rd_addr2=23 reads 8, reg 18 reads 0, all rd_busy 0, pending_cnt 0.
- Issue to 9 at cycle n, then write 9 = 0x1234 at cycle n+3 -> rd_busy1 (addr 9) = 1 in cycles n+1..n+2; during n+3 rd_data1 = 0x1234 with busy 0 (BYPASS=1); pending_cnt goes 0→1→0.
- Issue to 9 again while busy -> issue_ok=0, pending_cnt unchanged; same cycle plus wr_en to 9 -> issue_ok=1, busy stays 1 after the edge, pending_cnt unchanged.
- Write 0xFFFF_FFFF to 0 and issue to 0 -> reg 0 reads 0, busy 0, issue_ok=1, pending_cnt 0.
- Issue to 5, 6, 7 in consecutive cycles, then assert reset asynchronously between edges -> all busy 0 and pending_cnt 0 immediately, registers back to reset values.
- Toggle wr_en with no clk edge -> array unchanged. With BYPASS=0, a same-cycle read of the written address -> old value until after the edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with an integrated write-pending
// scoreboard for the pipelined MIPS datapath (ID/WB stages).
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, depth = 2**ADDR_W
//   BYPASS    1 = same-cycle write data forwarded to the read ports
//   ZERO_REG  1 = register 0 hardwired to zero and never busy
//   INIT_TEST 1 = reset loads test values into registers 8..23
//
// Ports
//   clk, reset               clock (rising edge) / async active-high reset
//   rd_addr1/2 -> rd_data1/2 combinational read ports
//   rd_busy1/2               addressed register has a pending write
//   wr_en, wr_addr, wr_data  clocked write-back port (clears busy)
//   issue_en, issue_addr     request to mark a destination pending
//   issue_ok                 issue accepted this cycle (combinational)
//   pending_cnt              registered count of busy registers
module reg_file_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit BYPASS    = 1'b1,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit INIT_TEST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ok,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    typedef struct packed {
        logic              busy;
        logic [DATA_W-1:0] data;
    } readResult_t;

    logic [DATA_W-1:0] regArray [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              writeEff;
    logic              issueSet;
    logic              cntInc;
    logic              cntDec;
    readResult_t       port1;
    readResult_t       port2;

    function automatic logic [DATA_W-1:0] resetValue(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (INIT_TEST) begin
            case (idx)
                8:  v = DATA_W'(10);
                9:  v = DATA_W'(20);
                10: v = DATA_W'(22);
                11: v = DATA_W'(40);
                12: v = DATA_W'(50);
                13: v = DATA_W'(60);
                14: v = DATA_W'(70);
                15: v = DATA_W'(80);
                16: v = DATA_W'(1);
                17: v = DATA_W'(2);
                18: v = DATA_W'(0);
                19: v = DATA_W'(4);
                20: v = DATA_W'(5);
                21: v = DATA_W'(6);
                22: v = DATA_W'(7);
                23: v = DATA_W'(8);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic readResult_t readPort(input logic [ADDR_W-1:0] addr);
        readResult_t r;
        if (ZERO_REG && addr == '0) begin
            r.busy = 1'b0;
            r.data = '0;
        end else if (BYPASS && wr_en && wr_addr == addr) begin
            // Forwarded writeback: the value being written is current, so the
            // register is no longer considered pending.
            r.busy = 1'b0;
            r.data = wr_data;
        end else begin
            r.busy = busy[addr];
            r.data = regArray[addr];
        end
        return r;
    endfunction

    always_comb begin
        port1 = readPort(rd_addr1);
        port2 = readPort(rd_addr2);
    end

    assign rd_data1 = port1.data;
    assign rd_busy1 = port1.busy;
    assign rd_data2 = port2.data;
    assign rd_busy2 = port2.busy;

    assign writeEff = wr_en && !(ZERO_REG && wr_addr == '0);

    // busy[0] is never set when ZERO_REG=1, so issue to register 0 is always
    // accepted without any special case here.
    assign issue_ok = issue_en && (!busy[issue_addr] || (wr_en && wr_addr == issue_addr));
    assign issueSet = issue_ok && !(ZERO_REG && issue_addr == '0);

    // NOTE: every variable written in always_comb gets a default first so no
    // latch is inferred; later assignments then override earlier ones.
    always_comb begin
        busyNext = busy;
        if (writeEff) busyNext[wr_addr] = 1'b0;
        // Set after clear: an issue and a writeback to the same register in
        // one cycle leaves the register busy.
        if (issueSet) busyNext[issue_addr] = 1'b1;
    end

    // Incremental population count: a bit rising adds one, a bit falling
    // subtracts one, a set bit re-set by a same-cycle issue is neutral.
    assign cntInc = issueSet && !busy[issue_addr];
    assign cntDec = writeEff && busy[wr_addr] && !(issueSet && issue_addr == wr_addr);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset deliberately; the datapath relies on
            // known register contents (and test values) straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                regArray[i] <= resetValue(i);
            end
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (writeEff) regArray[wr_addr] <= wr_data;
            busy        <= busyNext;
            pending_cnt <= pending_cnt + (ADDR_W+1)'(cntInc) - (ADDR_W+1)'(cntDec);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb. Two instances share all inputs:
//   dutA: BYPASS=1, ZERO_REG=1, INIT_TEST=1
//   dutB: BYPASS=0, ZERO_REG=1, INIT_TEST=0
// A directed table, a few hand-written sequences and a randomized phase
// checked against an array-based reference model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rdAddr1, rdAddr2, wrAddr, issueAddr;
    logic [31:0] wrData;
    logic        wrEn, issueEn;

    logic [31:0] rdData1A, rdData2A, rdData1B, rdData2B;
    logic        rdBusy1A, rdBusy2A, rdBusy1B, rdBusy2B;
    logic        issueOkA, issueOkB;
    logic [5:0]  pendingCntA, pendingCntB;

    int nVec  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1), .INIT_TEST(1'b1)) dutA (
        .clk(clk), .reset(reset),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(rdData1A), .rd_data2(rdData2A),
        .rd_busy1(rdBusy1A), .rd_busy2(rdBusy2A),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .issue_en(issueEn), .issue_addr(issueAddr),
        .issue_ok(issueOkA), .pending_cnt(pendingCntA)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1), .INIT_TEST(1'b0)) dutB (
        .clk(clk), .reset(reset),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(rdData1B), .rd_data2(rdData2B),
        .rd_busy1(rdBusy1B), .rd_busy2(rdBusy2B),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .issue_en(issueEn), .issue_addr(issueAddr),
        .issue_ok(issueOkB), .pending_cnt(pendingCntB)
    );

    // ---------------- reference model ----------------
    // Instance 0 models dutA (bypass, test init), instance 1 models dutB.
    logic [31:0] mReg [2][32];
    bit          mBusy [32];
    int          initList [16] = '{10, 20, 22, 40, 50, 60, 70, 80, 1, 2, 0, 4, 5, 6, 7, 8};

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mReg[0][i] = 32'h0;
            mReg[1][i] = 32'h0;
            mBusy[i]   = 1'b0;
        end
        for (int k = 0; k < 16; k++) mReg[0][8+k] = initList[k];
    endtask

    function automatic logic [31:0] expRead(input int inst, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (inst == 0 && wrEn && wrAddr == a) return wrData;
        return mReg[inst][a];
    endfunction

    function automatic logic expBusy(input int inst, input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (inst == 0 && wrEn && wrAddr == a) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic logic expIssueOk();
        if (!issueEn) return 1'b0;
        return (issueAddr == 0) || !mBusy[issueAddr] || (wrEn && wrAddr == issueAddr);
    endfunction

    function automatic logic [31:0] expCount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mBusy[i]);
        return c;
    endfunction

    task automatic modelClock();
        logic ok;
        ok = expIssueOk();
        if (wrEn && wrAddr != 0) begin
            mReg[0][wrAddr] = wrData;
            mReg[1][wrAddr] = wrData;
            mBusy[wrAddr]   = 1'b0;
        end
        if (ok && issueAddr != 0) mBusy[issueAddr] = 1'b1;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: advance one clock edge, keeping the model in step.
    task automatic cycle();
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic setIdle();
        wrEn = 1'b0; wrAddr = '0; wrData = '0;
        issueEn = 1'b0; issueAddr = '0;
    endtask

    task automatic checkAllVsModel(input string tag);
        check({tag, " rd_data1 A"}, rdData1A, expRead(0, rdAddr1));
        check({tag, " rd_data2 A"}, rdData2A, expRead(0, rdAddr2));
        check({tag, " rd_data1 B"}, rdData1B, expRead(1, rdAddr1));
        check({tag, " rd_data2 B"}, rdData2B, expRead(1, rdAddr2));
        check({tag, " rd_busy1 A"}, 32'(rdBusy1A), 32'(expBusy(0, rdAddr1)));
        check({tag, " rd_busy2 A"}, 32'(rdBusy2A), 32'(expBusy(0, rdAddr2)));
        check({tag, " rd_busy1 B"}, 32'(rdBusy1B), 32'(expBusy(1, rdAddr1)));
        check({tag, " rd_busy2 B"}, 32'(rdBusy2B), 32'(expBusy(1, rdAddr2)));
        check({tag, " issue_ok A"}, 32'(issueOkA), 32'(expIssueOk()));
        check({tag, " issue_ok B"}, 32'(issueOkB), 32'(expIssueOk()));
        check({tag, " pending_cnt A"}, 32'(pendingCntA), expCount());
        check({tag, " pending_cnt B"}, 32'(pendingCntB), expCount());
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        issEn;
        logic [4:0]  issAddr;
        logic [4:0]  ra1, ra2;
        logic [31:0] expD1A;
        logic        expB1A;
        logic [31:0] expD2A;
        logic [31:0] expD1B;
        logic        expB1B;
        logic        expOk;
        logic [5:0]  expCnt;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d1a, input logic b1a, input logic [31:0] d2a,
                                input logic [31:0] d1b, input logic b1b,
                                input logic ok, input logic [5:0] cnt);
        vec_t v;
        v.wrEn = we; v.wrAddr = wa; v.wrData = wd; v.issEn = ie; v.issAddr = ia;
        v.ra1 = a1; v.ra2 = a2; v.expD1A = d1a; v.expB1A = b1a; v.expD2A = d2a;
        v.expD1B = d1b; v.expB1B = b1b; v.expOk = ok; v.expCnt = cnt;
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        // Each row is applied after a rising edge and checked before the next.
        vecs[0]  = mk(0, 0,  0,            0, 0,  8,  23, 10,       0, 8,        0,        0, 0, 0);
        vecs[1]  = mk(0, 0,  0,            1, 9,  18, 8,  0,        0, 10,       0,        0, 1, 0);
        vecs[2]  = mk(0, 0,  0,            0, 0,  9,  9,  20,       1, 20,       0,        1, 0, 1);
        vecs[3]  = mk(0, 0,  0,            1, 9,  9,  9,  20,       1, 20,       0,        1, 0, 1);
        vecs[4]  = mk(1, 9,  32'h1234,     0, 0,  9,  9,  32'h1234, 0, 32'h1234, 0,        1, 0, 1);
        vecs[5]  = mk(0, 0,  0,            1, 9,  9,  9,  32'h1234, 0, 32'h1234, 32'h1234, 0, 1, 0);
        vecs[6]  = mk(1, 9,  32'h55,       1, 9,  9,  9,  32'h55,   0, 32'h55,   32'h1234, 1, 1, 1);
        vecs[7]  = mk(0, 0,  0,            0, 0,  9,  9,  32'h55,   1, 32'h55,   32'h55,   1, 0, 1);
        vecs[8]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,        0, 0,        0,        0, 1, 1);
        vecs[9]  = mk(0, 0,  0,            0, 0,  0,  9,  0,        0, 32'h55,   0,        0, 0, 1);
        vecs[10] = mk(1, 9,  32'h77,       0, 0,  9,  8,  32'h77,   0, 10,       32'h55,   1, 0, 1);
        vecs[11] = mk(0, 0,  0,            0, 0,  9,  8,  32'h77,   0, 10,       32'h77,   0, 0, 0);
        vecs[12] = mk(1, 12, 32'hABCD,     0, 0,  12, 12, 32'hABCD, 0, 32'hABCD, 0,        0, 0, 0);
        vecs[13] = mk(1, 13, 32'h99,       1, 13, 12, 13, 32'hABCD, 0, 32'h99,   32'hABCD, 0, 1, 0);
        vecs[14] = mk(0, 0,  0,            0, 0,  13, 13, 32'h99,   1, 32'h99,   32'h99,   1, 0, 1);
        vecs[15] = mk(1, 13, 0,            0, 0,  13, 13, 0,        0, 0,        32'h99,   1, 0, 1);
        vecs[16] = mk(0, 0,  0,            0, 0,  13, 13, 0,        0, 0,        0,        0, 0, 0);

        // ---------------- reset ----------------
        reset = 1'b1;
        setIdle();
        rdAddr1 = 5'd0; rdAddr2 = 5'd0;
        modelReset();
        #12;
        reset = 1'b0;          // released between edges
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < 17; i++) begin
            wrEn = vecs[i].wrEn; wrAddr = vecs[i].wrAddr; wrData = vecs[i].wrData;
            issueEn = vecs[i].issEn; issueAddr = vecs[i].issAddr;
            rdAddr1 = vecs[i].ra1; rdAddr2 = vecs[i].ra2;
            #2;
            check($sformatf("vec%0d rd_data1 A", i), rdData1A, vecs[i].expD1A);
            check($sformatf("vec%0d rd_busy1 A", i), 32'(rdBusy1A), 32'(vecs[i].expB1A));
            check($sformatf("vec%0d rd_data2 A", i), rdData2A, vecs[i].expD2A);
            check($sformatf("vec%0d rd_data1 B", i), rdData1B, vecs[i].expD1B);
            check($sformatf("vec%0d rd_busy1 B", i), 32'(rdBusy1B), 32'(vecs[i].expB1B));
            check($sformatf("vec%0d issue_ok A", i), 32'(issueOkA), 32'(vecs[i].expOk));
            check($sformatf("vec%0d issue_ok B", i), 32'(issueOkB), 32'(vecs[i].expOk));
            check($sformatf("vec%0d pending_cnt A", i), 32'(pendingCntA), 32'(vecs[i].expCnt));
            check($sformatf("vec%0d pending_cnt B", i), 32'(pendingCntB), 32'(vecs[i].expCnt));
            cycle();
        end

        // ---------------- wr_en toggled without a clock edge ----------------
        setIdle();
        rdAddr1 = 5'd10; rdAddr2 = 5'd10;
        wrAddr = 5'd10; wrData = 32'hDEAD;
        wrEn = 1'b1; #1; wrEn = 1'b0; #1;
        check("toggle no-edge reg10 A", rdData1A, 32'd22);
        check("toggle no-edge reg10 B", rdData1B, 32'd0);
        cycle();
        check("toggle after-edge reg10 A", rdData1A, 32'd22);
        check("toggle after-edge reg10 B", rdData1B, 32'd0);

        // ---------------- no-bypass same-cycle read ----------------
        wrEn = 1'b1; wrAddr = 5'd10; wrData = 32'hBEEF;
        #2;
        check("same-cycle read B old", rdData1B, 32'd0);
        check("same-cycle read A bypass", rdData1A, 32'hBEEF);
        cycle();
        setIdle();
        #2;
        check("post-edge read B new", rdData1B, 32'hBEEF);
        check("post-edge read A new", rdData1A, 32'hBEEF);

        // ---------------- issue 5,6,7 then async reset ----------------
        issueEn = 1'b1;
        issueAddr = 5'd5; cycle();
        issueAddr = 5'd6; cycle();
        issueAddr = 5'd7; cycle();
        setIdle();
        rdAddr1 = 5'd5; rdAddr2 = 5'd7;
        #2;
        check("pre-reset pending_cnt A", 32'(pendingCntA), 32'd3);
        check("pre-reset pending_cnt B", 32'(pendingCntB), 32'd3);
        check("pre-reset busy5 A", 32'(rdBusy1A), 32'd1);
        reset = 1'b1;          // mid-cycle, no clock edge
        #1;
        check("async reset pending_cnt A", 32'(pendingCntA), 32'd0);
        check("async reset pending_cnt B", 32'(pendingCntB), 32'd0);
        check("async reset busy5 A", 32'(rdBusy1A), 32'd0);
        check("async reset busy7 B", 32'(rdBusy2B), 32'd0);
        rdAddr1 = 5'd9; rdAddr2 = 5'd10;
        #1;
        check("async reset reg9 A", rdData1A, 32'd20);
        check("async reset reg10 A", rdData2A, 32'd22);
        check("async reset reg10 B", rdData2B, 32'd0);
        reset = 1'b0;
        modelReset();
        cycle();

        // ---------------- randomized vs model ----------------
        for (int n = 0; n < 400; n++) begin
            wrEn      = ($urandom_range(0, 1) == 1);
            issueEn   = ($urandom_range(0, 1) == 1);
            wrAddr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            issueAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rdAddr1   = 5'($urandom_range(0, 7));
            rdAddr2   = ($urandom_range(0, 1) == 1) ? wrAddr : 5'($urandom_range(0, 31));
            wrData    = $urandom;
            #2;
            checkAllVsModel($sformatf("rnd%0d", n));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
